// File: rtl/id_pkg.sv
// Shared decode constants, branch classification and ID/EX tag record
// for the instruction-decode stage.
package id_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [4:0] REG_RA     = 5'd31;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_J,
    BR_JAL,
    BR_JR
  } br_kind_e;

  typedef struct packed {
    logic       valid;
    logic       write;
    logic [4:0] dest;
  } id_ex_tag_t;

  function automatic br_kind_e br_kind(input logic [31:0] instr);
    br_kind_e k;
    k = BR_NONE;
    case (instr[31:26])
      OP_BEQ:     k = BR_BEQ;
      OP_BNE:     k = BR_BNE;
      OP_J:       k = BR_J;
      OP_JAL:     k = BR_JAL;
      OP_SPECIAL: if (instr[5:0] == FN_JR) k = BR_JR;
      default:    k = BR_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/id_fwd_unit.sv
// Resolves one source operand against the forwarding sources and flags a
// hazard when the winning source has not yet produced its value.
module id_fwd_unit
  import id_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEFAULT,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic [4:0]              addr,
  input  logic                    used,
  input  logic [XLEN-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  input  logic [5*NUM_FWD-1:0]    fwd_reg,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  output logic [XLEN-1:0]         data,
  output logic                    hazard
);

  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    if (addr == '0) begin
      data = '0;
    end else begin
      // Scan oldest to youngest so the lowest matching index is applied last.
      for (int unsigned i = NUM_FWD; i > 0; i--) begin
        if (fwd_valid[i-1] && (fwd_reg[5*(i-1) +: 5] == addr)) begin
          data   = fwd_data[XLEN*(i-1) +: XLEN];
          hazard = used & fwd_pending[i-1];
        end
      end
    end
  end

endmodule

// File: rtl/id_stage_p.sv
// Instruction-decode stage: operand forwarding, load-use stall, branch/jump
// resolution and the ID/EX pipeline register.
module id_stage_p
  import id_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEFAULT,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CTL_W   = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_valid,
  input  logic [31:0]             if_instruction,
  input  logic [XLEN-1:0]         if_pc4,
  output logic                    id_ready,
  input  logic [CTL_W-1:0]        dec_ctl,
  input  logic                    dec_uses_rs,
  input  logic                    dec_uses_rt,
  input  logic                    dec_writes,
  input  logic [4:0]              dec_dest,
  output logic [4:0]              rf_rs_addr,
  output logic [4:0]              rf_rt_addr,
  input  logic [XLEN-1:0]         rf_rs_data,
  input  logic [XLEN-1:0]         rf_rt_data,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  input  logic [5*NUM_FWD-1:0]    fwd_reg,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic                    ex_ready,
  input  logic                    flush,
  output logic                    jump,
  output logic [XLEN-1:0]         jump_pc,
  output logic                    ex_valid,
  output logic [CTL_W-1:0]        ex_ctl,
  output logic [XLEN-1:0]         ex_a,
  output logic [XLEN-1:0]         ex_b,
  output logic [XLEN-1:0]         ex_imm,
  output logic [4:0]              ex_dest,
  output logic                    ex_write,
  output logic [XLEN-1:0]         ex_pc4,
  output logic [15:0]             stall_count
);

  br_kind_e        br;
  logic            use_rs, use_rt;
  logic            haz_rs, haz_rt;
  logic            hazard, fire, taken;
  logic [XLEN-1:0] rs_val, rt_val;
  logic [XLEN-1:0] imm_sext, br_target, j_target, target;
  logic [XLEN-1:0] a_next;
  id_ex_tag_t      tag_next, ex_tag;

  assign rf_rs_addr = if_instruction[25:21];
  assign rf_rt_addr = if_instruction[20:16];

  // Branch sources count as used even if the external decoder leaves them clear.
  assign br     = br_kind(if_instruction);
  assign use_rs = dec_uses_rs | (br == BR_BEQ) | (br == BR_BNE) | (br == BR_JR);
  assign use_rt = dec_uses_rt | (br == BR_BEQ) | (br == BR_BNE);

  id_fwd_unit #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs (
    .addr        (rf_rs_addr),
    .used        (use_rs),
    .rf_data     (rf_rs_data),
    .fwd_valid   (fwd_valid),
    .fwd_pending (fwd_pending),
    .fwd_reg     (fwd_reg),
    .fwd_data    (fwd_data),
    .data        (rs_val),
    .hazard      (haz_rs)
  );

  id_fwd_unit #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rt (
    .addr        (rf_rt_addr),
    .used        (use_rt),
    .rf_data     (rf_rt_data),
    .fwd_valid   (fwd_valid),
    .fwd_pending (fwd_pending),
    .fwd_reg     (fwd_reg),
    .fwd_data    (fwd_data),
    .data        (rt_val),
    .hazard      (haz_rt)
  );

  assign hazard   = if_valid & (haz_rs | haz_rt);
  assign fire     = if_valid & ~hazard & ex_ready & ~flush;
  assign id_ready = fire | ~if_valid | flush;

  assign imm_sext  = {{(XLEN-16){if_instruction[15]}}, if_instruction[15:0]};
  assign br_target = if_pc4 + {imm_sext[XLEN-3:0], 2'b00};
  assign j_target  = {if_pc4[XLEN-1:28], if_instruction[25:0], 2'b00};

  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (br)
      BR_BEQ: begin
        taken  = (rs_val == rt_val);
        target = br_target;
      end
      BR_BNE: begin
        taken  = (rs_val != rt_val);
        target = br_target;
      end
      BR_J, BR_JAL: begin
        taken  = 1'b1;
        target = j_target;
      end
      BR_JR: begin
        taken  = 1'b1;
        target = rs_val;
      end
      default: begin
        taken  = 1'b0;
        target = '0;
      end
    endcase
  end

  assign jump    = fire & taken & ~reset;
  assign jump_pc = jump ? target : '0;

  always_comb begin
    tag_next.valid = 1'b1;
    tag_next.write = dec_writes;
    tag_next.dest  = dec_dest;
    a_next         = rs_val;
    if (br == BR_JAL) begin
      tag_next.write = 1'b1;
      tag_next.dest  = REG_RA;
      a_next         = if_pc4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_tag      <= '0;
      ex_ctl      <= '0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_pc4      <= '0;
      stall_count <= '0;
    end else begin
      if (ex_ready) begin
        if (fire) begin
          ex_tag <= tag_next;
          ex_ctl <= dec_ctl;
          ex_a   <= a_next;
          ex_b   <= rt_val;
          ex_imm <= imm_sext;
          ex_pc4 <= if_pc4;
        end else begin
          ex_tag <= '0;
          ex_ctl <= '0;
          ex_a   <= '0;
          ex_b   <= '0;
          ex_imm <= '0;
          ex_pc4 <= '0;
        end
      end
      if (hazard && ex_ready && !flush && (stall_count != '1))
        stall_count <= stall_count + 16'd1;
    end
  end

  assign ex_valid = ex_tag.valid;
  assign ex_write = ex_tag.write;
  assign ex_dest  = ex_tag.dest;

endmodule

// File: tb/tb_id_stage_p.sv
// Randomized and directed bench for id_stage_p against a behavioural model
// of the decode stage (operand lookup, stall rule, branch targets, ID/EX).
module tb_id_stage_p;

  localparam int XLEN    = 32;
  localparam int NUM_FWD = 2;
  localparam int CTL_W   = 12;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    if_valid;
  logic [31:0]             if_instruction;
  logic [XLEN-1:0]         if_pc4;
  logic                    id_ready;
  logic [CTL_W-1:0]        dec_ctl;
  logic                    dec_uses_rs, dec_uses_rt, dec_writes;
  logic [4:0]              dec_dest;
  logic [4:0]              rf_rs_addr, rf_rt_addr;
  logic [XLEN-1:0]         rf_rs_data, rf_rt_data;
  logic [NUM_FWD-1:0]      fwd_valid, fwd_pending;
  logic [5*NUM_FWD-1:0]    fwd_reg;
  logic [XLEN*NUM_FWD-1:0] fwd_data;
  logic                    ex_ready, flush;
  logic                    jump;
  logic [XLEN-1:0]         jump_pc;
  logic                    ex_valid;
  logic [CTL_W-1:0]        ex_ctl;
  logic [XLEN-1:0]         ex_a, ex_b, ex_imm, ex_pc4;
  logic [4:0]              ex_dest;
  logic                    ex_write;
  logic [15:0]             stall_count;

  id_stage_p #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CTL_W(CTL_W)) dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_instruction(if_instruction), .if_pc4(if_pc4),
    .id_ready(id_ready),
    .dec_ctl(dec_ctl), .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
    .dec_writes(dec_writes), .dec_dest(dec_dest),
    .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .ex_ready(ex_ready), .flush(flush),
    .jump(jump), .jump_pc(jump_pc),
    .ex_valid(ex_valid), .ex_ctl(ex_ctl), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_dest(ex_dest), .ex_write(ex_write), .ex_pc4(ex_pc4),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state of the ID/EX register and stall counter.
  logic            m_valid, m_write;
  logic [CTL_W-1:0] m_ctl;
  logic [31:0]     m_a, m_b, m_imm, m_pc4;
  logic [4:0]      m_dest;
  logic [15:0]     m_stall;
  logic            n_valid, n_write;
  logic [CTL_W-1:0] n_ctl;
  logic [31:0]     n_a, n_b, n_imm, n_pc4;
  logic [4:0]      n_dest;
  logic [15:0]     n_stall;

  task automatic resolve(input logic [4:0] r, input logic [31:0] rfd,
                         output logic [31:0] d, output logic pend);
    bit found;
    d = rfd;
    pend = 1'b0;
    found = 0;
    if (r == 5'd0) begin
      d = 32'd0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!found && fwd_valid[i] && fwd_reg[5*i +: 5] == r) begin
          found = 1;
          d = fwd_data[32*i +: 32];
          pend = fwd_pending[i];
        end
      end
    end
  endtask

  task automatic step_pre();
    logic [5:0]  op, fn;
    logic [31:0] a, b, imm, tgt;
    logic        pa, pb, beq, bne, j, jal, jr, hz, fire, taken, e_jump;
    op  = if_instruction[31:26];
    fn  = if_instruction[5:0];
    beq = (op == 6'd4);
    bne = (op == 6'd5);
    j   = (op == 6'd2);
    jal = (op == 6'd3);
    jr  = (op == 6'd0) && (fn == 6'd8);
    resolve(if_instruction[25:21], rf_rs_data, a, pa);
    resolve(if_instruction[20:16], rf_rt_data, b, pb);
    hz    = if_valid && (((dec_uses_rs || beq || bne || jr) && pa) ||
                         ((dec_uses_rt || beq || bne) && pb));
    fire  = if_valid && !hz && ex_ready && !flush;
    imm   = {{16{if_instruction[15]}}, if_instruction[15:0]};
    taken = (beq && a == b) || (bne && a != b) || j || jal || jr;
    if (beq || bne)     tgt = if_pc4 + imm * 4;
    else if (j || jal)  tgt = {if_pc4[31:28], if_instruction[25:0], 2'b00};
    else                tgt = a;
    e_jump = fire && taken && !reset;
    #1;
    check("rs_addr", rf_rs_addr, if_instruction[25:21]);
    check("rt_addr", rf_rt_addr, if_instruction[20:16]);
    check("jump", jump, e_jump);
    check("jump_pc", jump_pc, e_jump ? tgt : 32'd0);
    if (!reset) check("id_ready", id_ready, fire || !if_valid || flush);

    {n_valid, n_write, n_ctl, n_a, n_b, n_imm, n_pc4, n_dest, n_stall} =
      {m_valid, m_write, m_ctl, m_a, m_b, m_imm, m_pc4, m_dest, m_stall};
    if (reset) begin
      {n_valid, n_write, n_ctl, n_a, n_b, n_imm, n_pc4, n_dest, n_stall} = '0;
    end else begin
      if (ex_ready && fire) begin
        n_valid = 1'b1;
        n_ctl   = dec_ctl;
        n_a     = jal ? if_pc4 : a;
        n_b     = b;
        n_imm   = imm;
        n_pc4   = if_pc4;
        n_dest  = jal ? 5'd31 : dec_dest;
        n_write = jal ? 1'b1 : dec_writes;
      end else if (ex_ready) begin
        {n_valid, n_write, n_ctl, n_a, n_b, n_imm, n_pc4, n_dest} = '0;
      end
      if (hz && ex_ready && !flush && m_stall != 16'hFFFF) n_stall = m_stall + 16'd1;
    end
  endtask

  task automatic step_post();
    @(posedge clock);
    #1;
    {m_valid, m_write, m_ctl, m_a, m_b, m_imm, m_pc4, m_dest, m_stall} =
      {n_valid, n_write, n_ctl, n_a, n_b, n_imm, n_pc4, n_dest, n_stall};
    check("ex_valid", ex_valid, m_valid);
    check("ex_write", ex_write, m_write);
    check("ex_ctl", ex_ctl, m_ctl);
    check("ex_a", ex_a, m_a);
    check("ex_b", ex_b, m_b);
    check("ex_imm", ex_imm, m_imm);
    check("ex_pc4", ex_pc4, m_pc4);
    check("ex_dest", ex_dest, m_dest);
    check("stall_count", stall_count, m_stall);
  endtask

  task automatic step();
    step_pre();
    step_post();
  endtask

  task automatic idle();
    reset = 0; if_valid = 0; if_instruction = 0; if_pc4 = 0;
    dec_ctl = 0; dec_uses_rs = 0; dec_uses_rt = 0; dec_writes = 0; dec_dest = 0;
    rf_rs_data = 0; rf_rt_data = 0;
    fwd_valid = 0; fwd_pending = 0; fwd_reg = 0; fwd_data = 0;
    ex_ready = 1; flush = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 7))
      0: w[31:26] = 6'h04;
      1: w[31:26] = 6'h05;
      2: w[31:26] = 6'h02;
      3: w[31:26] = 6'h03;
      4: begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
      5: w[31:26] = 6'h23;
      default: w[31:26] = 6'h00;
    endcase
    w[25:21] = 5'($urandom_range(0, 6));
    w[20:16] = 5'($urandom_range(0, 6));
    return w;
  endfunction

  function automatic logic [31:0] rand_data();
    return ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'($urandom);
  endfunction

  initial begin
    idle();
    do_reset();

    // Youngest forwarding source wins over older source and register file.
    if_valid = 1; if_instruction = 32'h0022_1820; if_pc4 = 32'h40;
    dec_uses_rs = 1; dec_uses_rt = 1; dec_writes = 1; dec_dest = 5'd3; dec_ctl = 12'h5A5;
    fwd_valid = 2'b11; fwd_reg = {5'd1, 5'd1}; fwd_data = {32'h22, 32'h11};
    rf_rs_data = 32'h33; rf_rt_data = 32'h44;
    step();
    check("fwd_priority_ex_a", ex_a, 32'h11);

    // Load-use stall then release.
    do_reset();
    if_valid = 1; if_instruction = 32'h00A0_3020; if_pc4 = 32'h80;
    dec_uses_rs = 1; dec_uses_rt = 1; dec_writes = 1; dec_dest = 5'd6;
    fwd_valid = 2'b01; fwd_pending = 2'b01; fwd_reg = {5'd0, 5'd5}; fwd_data = {32'h0, 32'h77};
    step_pre();
    check("load_use_id_ready", id_ready, 1'b0);
    step_post();
    check("load_use_bubble", ex_valid, 1'b0);
    check("load_use_stall", stall_count, 16'd1);
    fwd_pending = 2'b00;
    step();
    check("load_use_issue", ex_valid, 1'b1);
    check("load_use_ex_a", ex_a, 32'h77);

    // beq taken / bne not taken on same register.
    idle();
    if_valid = 1; if_instruction = 32'h1084_0003; if_pc4 = 32'h100;
    rf_rs_data = 32'h9; rf_rt_data = 32'h9;
    step_pre();
    check("beq_jump", jump, 1'b1);
    check("beq_target", jump_pc, 32'h10C);
    step_post();
    if_instruction = 32'h1484_0003;
    step_pre();
    check("bne_jump", jump, 1'b0);
    step_post();

    // Backpressure: three cycles of ex_ready=0.
    if_instruction = 32'h0022_1820; dec_uses_rs = 1; dec_uses_rt = 1;
    rf_rs_data = 32'hAB; rf_rt_data = 32'hCD;
    ex_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step_pre();
      check("hold_id_ready", id_ready, 1'b0);
      step_post();
    end
    ex_ready = 1;

    // Flush while a hazard is present on a branch source.
    do_reset();
    if_valid = 1; if_instruction = 32'h10A5_0002; if_pc4 = 32'h200;
    fwd_valid = 2'b01; fwd_pending = 2'b01; fwd_reg = {5'd0, 5'd5};
    flush = 1;
    step_pre();
    check("flush_jump", jump, 1'b0);
    step_post();
    check("flush_bubble", ex_valid, 1'b0);
    check("flush_no_stall", stall_count, 16'd0);
    flush = 0;

    // Reset during a stall.
    for (int k = 0; k < 7; k++) step();
    check("stall_seven", stall_count, 16'd7);
    reset = 1;
    step();
    check("reset_stall", stall_count, 16'd0);
    check("reset_valid", ex_valid, 1'b0);
    reset = 0;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 99) < 2);
      if_valid       = ($urandom_range(0, 9) < 8);
      if_instruction = rand_instr();
      if_pc4         = $urandom;
      dec_ctl        = 12'($urandom);
      dec_uses_rs    = 1'($urandom);
      dec_uses_rt    = 1'($urandom);
      dec_writes     = 1'($urandom);
      dec_dest       = 5'($urandom);
      rf_rs_data     = rand_data();
      rf_rt_data     = rand_data();
      for (int i = 0; i < NUM_FWD; i++) begin
        fwd_valid[i]         = 1'($urandom);
        fwd_pending[i]       = ($urandom_range(0, 3) == 0);
        fwd_reg[5*i +: 5]    = 5'($urandom_range(0, 6));
        fwd_data[32*i +: 32] = rand_data();
      end
      ex_ready = ($urandom_range(0, 9) < 8);
      flush    = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
